// File: rtl/copy_engine_pkg.sv
// Shared types, register map and helpers for the copy-engine command queue.
// Imported by the command FIFO and the Avalon wrapper.
package copy_engine_pkg;

  localparam int unsigned DEPTH_C      = 16;
  localparam int unsigned COORD_W_C    = 10;
  localparam int unsigned SRC_ADDR_W_C = 20;
  localparam int unsigned PAL_W_C      = 2;

  typedef struct packed {
    logic [COORD_W_C-1:0]    x_start;
    logic [COORD_W_C-1:0]    x_end;
    logic [COORD_W_C-1:0]    y_start;
    logic [COORD_W_C-1:0]    y_end;
    logic [SRC_ADDR_W_C-1:0] src_addr;
    logic [PAL_W_C-1:0]      palette;
    logic                    flip_x;
  } blit_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } cq_state_t;

  localparam logic [3:0] REG_X_START  = 4'd0;
  localparam logic [3:0] REG_X_END    = 4'd1;
  localparam logic [3:0] REG_Y_START  = 4'd2;
  localparam logic [3:0] REG_Y_END    = 4'd3;
  localparam logic [3:0] REG_SRC_ADDR = 4'd4;
  localparam logic [3:0] REG_PALETTE  = 4'd5;
  localparam logic [3:0] REG_FLIP_X   = 4'd6;
  localparam logic [3:0] REG_PUSH     = 4'd7;
  localparam logic [3:0] REG_STATUS   = 4'd8;
  localparam logic [3:0] REG_CONTROL  = 4'd9;
  localparam logic [3:0] REG_FRAME    = 4'd14;
  localparam logic [3:0] REG_DONE_CNT = 4'd15;

  localparam int unsigned ST_FULL     = 8;
  localparam int unsigned ST_EMPTY    = 9;
  localparam int unsigned ST_BUSY     = 10;
  localparam int unsigned ST_OVERFLOW = 11;
  localparam int unsigned ST_DRAIN    = 12;

  localparam int unsigned CTL_ENABLE  = 0;
  localparam int unsigned CTL_FLUSH   = 1;
  localparam int unsigned CTL_IRQ_EN  = 3;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush; head is visible on data_o.
// Flush and reset clear the pointers and count; storage is left as-is.
module cmd_fifo
  import copy_engine_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type         T     = blit_cmd_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  T                         data_i,
  output T                         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  T              mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  // Full/empty come from the pre-cycle count, so a push into a full queue
  // is refused even when a pop happens in the same cycle.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/copy_queue_wrapper.sv
// Avalon-MM front end that queues blit commands and sequences them onto an
// external copy_engine via its execute/done handshake.
module copy_queue_wrapper
  import copy_engine_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned SRC_ADDR_W = 20,
  parameter int unsigned PAL_W      = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic                  AVL_CS,
  input  logic [3:0]            AVL_BYTE_EN,
  input  logic [3:0]            AVL_ADDR,
  input  logic [31:0]           AVL_WRITEDATA,
  output logic [31:0]           AVL_READDATA,
  output logic [COORD_W-1:0]    eng_dest_x_start,
  output logic [COORD_W-1:0]    eng_dest_x_end,
  output logic [COORD_W-1:0]    eng_dest_y_start,
  output logic [COORD_W-1:0]    eng_dest_y_end,
  output logic [SRC_ADDR_W-1:0] eng_src_addr,
  output logic                  eng_flip_x,
  output logic                  eng_execute,
  input  logic                  eng_done,
  input  logic                  current_frame,
  output logic [PAL_W-1:0]      palette_index,
  output logic                  irq
);

  logic                    wr;
  logic                    rd;
  blit_cmd_t               stage_q;
  blit_cmd_t               active_q;
  blit_cmd_t               fifo_head;
  logic [31:0]             stage_rdata;
  logic [31:0]             status;
  logic                    enable_q;
  logic                    irq_en_q;
  logic                    overflow_q;
  logic                    drain_q;
  logic                    abort_q;
  logic                    exec_q;
  logic [15:0]             done_cnt_q;
  cq_state_t               state_q;
  logic                    flush;
  logic                    push_req;
  logic                    clr_ovf;
  logic                    clr_drain;
  logic                    fifo_pop;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign wr        = AVL_CS & AVL_WRITE;
  assign rd        = AVL_CS & AVL_READ;
  assign flush     = wr && (AVL_ADDR == REG_CONTROL) && AVL_BYTE_EN[0] && AVL_WRITEDATA[CTL_FLUSH];
  assign push_req  = wr && (AVL_ADDR == REG_PUSH);
  assign clr_ovf   = wr && (AVL_ADDR == REG_STATUS) && AVL_BYTE_EN[1] && AVL_WRITEDATA[ST_OVERFLOW];
  assign clr_drain = wr && (AVL_ADDR == REG_STATUS) && AVL_BYTE_EN[1] && AVL_WRITEDATA[ST_DRAIN];
  assign fifo_pop  = (state_q == LOAD);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (blit_cmd_t)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push_req & ~flush),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .data_i  (stage_q),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    stage_rdata = '0;
    case (AVL_ADDR)
      REG_X_START:  stage_rdata = 32'(stage_q.x_start);
      REG_X_END:    stage_rdata = 32'(stage_q.x_end);
      REG_Y_START:  stage_rdata = 32'(stage_q.y_start);
      REG_Y_END:    stage_rdata = 32'(stage_q.y_end);
      REG_SRC_ADDR: stage_rdata = 32'(stage_q.src_addr);
      REG_PALETTE:  stage_rdata = 32'(stage_q.palette);
      REG_FLIP_X:   stage_rdata = 32'(stage_q.flip_x);
      default:      stage_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stage_q <= '0;
    end else if (wr) begin
      case (AVL_ADDR)
        REG_X_START:  stage_q.x_start  <= COORD_W_C'(be_merge(stage_rdata, AVL_WRITEDATA, AVL_BYTE_EN));
        REG_X_END:    stage_q.x_end    <= COORD_W_C'(be_merge(stage_rdata, AVL_WRITEDATA, AVL_BYTE_EN));
        REG_Y_START:  stage_q.y_start  <= COORD_W_C'(be_merge(stage_rdata, AVL_WRITEDATA, AVL_BYTE_EN));
        REG_Y_END:    stage_q.y_end    <= COORD_W_C'(be_merge(stage_rdata, AVL_WRITEDATA, AVL_BYTE_EN));
        REG_SRC_ADDR: stage_q.src_addr <= SRC_ADDR_W_C'(be_merge(stage_rdata, AVL_WRITEDATA, AVL_BYTE_EN));
        REG_PALETTE:  stage_q.palette  <= PAL_W_C'(be_merge(stage_rdata, AVL_WRITEDATA, AVL_BYTE_EN));
        REG_FLIP_X:   stage_q.flip_x   <= AVL_BYTE_EN[0] ? AVL_WRITEDATA[0] : stage_q.flip_x;
        default:      stage_q          <= stage_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr && (AVL_ADDR == REG_CONTROL) && AVL_BYTE_EN[0]) begin
        enable_q <= AVL_WRITEDATA[CTL_ENABLE];
        irq_en_q <= AVL_WRITEDATA[CTL_IRQ_EN];
      end
      // A flush swallows a same-cycle push, so it is not an overflow.
      if (push_req && fifo_full && !flush) overflow_q <= 1'b1;
      else if (clr_ovf)                    overflow_q <= 1'b0;
    end
  end

  // abort_q marks a DONE entered via flush: no count, no drain interrupt.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      active_q   <= '0;
      exec_q     <= 1'b0;
      abort_q    <= 1'b0;
      drain_q    <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (clr_drain) drain_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_q && !fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          active_q <= fifo_head;
          exec_q   <= 1'b1;
          state_q  <= RUN;
        end
        RUN: begin
          if (flush) begin
            exec_q  <= 1'b0;
            abort_q <= 1'b1;
            state_q <= DONE;
          end else if (eng_done) begin
            exec_q     <= 1'b0;
            abort_q    <= 1'b0;
            done_cnt_q <= done_cnt_q + 16'd1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (!abort_q && fifo_empty) drain_q <= 1'b1;
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    status              = '0;
    status[7:0]         = 8'(fifo_count);
    status[ST_FULL]     = fifo_full;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_BUSY]     = (state_q != IDLE);
    status[ST_OVERFLOW] = overflow_q;
    status[ST_DRAIN]    = drain_q;
  end

  always_comb begin
    AVL_READDATA = '0;
    if (rd) begin
      case (AVL_ADDR)
        REG_X_START, REG_X_END, REG_Y_START, REG_Y_END,
        REG_SRC_ADDR, REG_PALETTE, REG_FLIP_X:
                      AVL_READDATA = stage_rdata;
        REG_STATUS:   AVL_READDATA = status;
        REG_CONTROL:  AVL_READDATA = 32'({irq_en_q, 2'b00, enable_q});
        REG_FRAME:    AVL_READDATA = 32'(current_frame);
        REG_DONE_CNT: AVL_READDATA = 32'(done_cnt_q);
        default:      AVL_READDATA = '0;
      endcase
    end
  end

  assign eng_dest_x_start = active_q.x_start;
  assign eng_dest_x_end   = active_q.x_end;
  assign eng_dest_y_start = active_q.y_start;
  assign eng_dest_y_end   = active_q.y_end;
  assign eng_src_addr     = active_q.src_addr;
  assign eng_flip_x       = active_q.flip_x;
  assign palette_index    = active_q.palette;
  assign eng_execute      = exec_q;
  assign irq              = drain_q & irq_en_q;

endmodule
